// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM with its clear sequencer.
//   clr_state_e  : clear-sequencer FSM states (ST_CLEAR, ST_READY)
//   addr_width() : address bits for a word count (minimum 1)
//   lane_count() : write lanes per word
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // At least one address bit, so that WORDS=1 still gets a usable port.
  function automatic int addr_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int lane_count(input int width, input int lane);
    return width / lane;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: after reset, or on request, it walks addresses
// 0..WORDS-1 at one word per cycle and then reports ready.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear       start a new clear (honoured only while ready)
//   clr_we      1 while the sequencer owns the write port
//   clr_addr    address being cleared this cycle
//   ready       1 once the clear has finished
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = addr_width(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        ready = 1'b1;
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (one write port, one registered read port, one clock)
// with per-lane write enables, write-first forwarding, and a built-in clear
// that fills every word with CLEAR_VALUE after reset or on clear_i.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   clear_i        start a full clear (sampled only while ready_o=1)
//   ready_o        1 = clear finished, read/write ports accepted
//   wr_en_i        write request; wr_addr_i, wr_lane_en_i, wr_data_i
//   rd_en_i        read request; rd_addr_i
//   rd_data_o      registered read data, held when no read completes
//   rd_valid_o     one-cycle pulse marking rd_data_o as fresh
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int                           WORDS       = 1024,
  parameter int                           WORD_WIDTH  = 8,
  parameter int                           LANE_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0]        CLEAR_VALUE = '0,
  parameter int                           AW          = addr_width(WORDS),
  parameter int                           LANES       = lane_count(WORD_WIDTH, LANE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  output logic                  ready_o,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [LANES-1:0]      wr_lane_en_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o
);

  if (WORD_WIDTH % LANE_WIDTH != 0) begin : g_lane_check
    $error("ram_dp_clr: WORD_WIDTH must be a multiple of LANE_WIDTH");
  end

  // One extra bit so WORDS itself is representable when WORDS = 2**AW.
  localparam logic [AW:0] WORDS_W = (AW + 1)'(WORDS);

  logic                  clr_we;
  logic [AW-1:0]         clr_addr;
  logic                  ready;

  ram_clear_seq #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_i),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign ready_o = ready;

  logic [WORD_WIDTH-1:0] mem [WORDS];

  logic wr_in_range, rd_in_range, wr_fire, rd_fire, fwd;
  logic [WORD_WIDTH-1:0] rd_word;

  assign wr_in_range = ({1'b0, wr_addr_i} < WORDS_W);
  assign rd_in_range = ({1'b0, rd_addr_i} < WORDS_W);

  // Port requests are ignored while clearing; out-of-range writes are dropped.
  assign wr_fire = ready && wr_en_i && wr_in_range && (|wr_lane_en_i);
  assign rd_fire = ready && rd_en_i;
  assign fwd     = wr_fire && (wr_addr_i == rd_addr_i);

  // NOTE: the storage array has no reset; its contents are established by
  // the clear sequencer, which lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VALUE;
    end else if (wr_fire) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_lane_en_i[k]) begin
          mem[wr_addr_i][k*LANE_WIDTH +: LANE_WIDTH] <= wr_data_i[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Write-first: a same-address write overrides the enabled lanes of the
  // word being read; out-of-range reads return CLEAR_VALUE.
  always_comb begin
    rd_word = rd_in_range ? mem[rd_addr_i] : CLEAR_VALUE;
    if (fwd) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_lane_en_i[k]) begin
          rd_word[k*LANE_WIDTH +: LANE_WIDTH] = wr_data_i[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_fire;
      if (rd_fire) begin
        rd_data_o <= rd_word;
      end
    end
  end

endmodule
